// File: rtl/ie_pkg.sv
// Shared definitions for the R-type execute stage: width defaults, function codes,
// multiply FSM encoding and the signed-overflow helper.
package ie_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_OP_DEF   = 6;
  localparam int NB_REG_DEF  = 5;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Two same-signed addends producing a differently-signed sum; SUB passes ~b_msb.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/ie_mul_iter.sv
// Iterative shift-add multiplier: start loads operands, NB_DATA iterations follow, done is high
// during the final iteration cycle; product is valid the cycle after done and held until next start.
module ie_mul_iter
  import ie_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   signed_op,
  input  logic [NB_DATA-1:0]     op_a,
  input  logic [NB_DATA-1:0]     op_b,
  output logic                   done,
  output logic [2*NB_DATA-1:0]   product
);

  localparam int NB_CNT = $clog2(NB_DATA);

  logic [2*NB_DATA-1:0] mcand;
  logic [2*NB_DATA-1:0] acc;
  logic [NB_DATA-1:0]   mplier;
  logic [NB_DATA-1:0]   mag_a;
  logic [NB_DATA-1:0]   mag_b;
  logic [NB_CNT-1:0]    cnt;
  logic                 busy;
  logic                 neg;

  // Signed multiply works on magnitudes; the sign is restored on the way out.
  always_comb begin
    mag_a = (signed_op && op_a[NB_DATA-1]) ? -op_a : op_a;
    mag_b = (signed_op && op_b[NB_DATA-1]) ? -op_b : op_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      neg    <= 1'b0;
    end else if (start) begin
      mcand  <= {{NB_DATA{1'b0}}, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
      neg    <= signed_op && (op_a[NB_DATA-1] ^ op_b[NB_DATA-1]);
    end else if (busy) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + NB_CNT'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

  assign done    = busy && (cnt == NB_CNT'(NB_DATA - 1));
  assign product = neg ? -acc : acc;

endmodule

// File: rtl/ie_pipe.sv
// R-type execute stage: single-cycle ALU/shift ops with latency 1 and no downstream backpressure;
// with IE_PIPE_MULT_EN defined, MULT/MULTU hold o_ready low for NB_DATA+1 cycles while HI/LO are computed.
module ie_pipe
  import ie_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF,
  parameter int NB_REG  = NB_REG_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [NB_DATA-1:0]  i_data_1,
  input  logic [NB_DATA-1:0]  i_data_2,
  input  logic [4:0]          i_shamt,
  input  logic [NB_OP-1:0]    i_code,
  input  logic [NB_REG-1:0]   i_rd,
  output logic                o_valid,
  output logic [NB_DATA-1:0]  o_alu_result,
  output logic [NB_REG-1:0]   o_rd,
  output logic                o_overflow,
  output logic                o_illegal
);

  localparam int NB_SH = $clog2(NB_DATA);
  localparam int MSB   = NB_DATA - 1;

  logic               accept;
  logic [NB_SH-1:0]   sh_fix;
  logic [NB_SH-1:0]   sh_var;
  logic [NB_DATA-1:0] sum;
  logic [NB_DATA-1:0] diff;
  logic [NB_DATA-1:0] res;
  logic               ovf;
  logic               ill;
  logic               is_mul;

`ifdef IE_PIPE_MULT_EN
  mul_state_e           state;
  logic [NB_DATA-1:0]   hi;
  logic [NB_DATA-1:0]   lo;
  logic                 mul_done;
  logic [2*NB_DATA-1:0] mul_product;
`endif

  assign accept = i_valid && o_ready;
  // Shift amounts wrap at the datapath width.
  assign sh_fix = NB_SH'(i_shamt);
  assign sh_var = i_data_1[NB_SH-1:0];
  assign sum    = i_data_1 + i_data_2;
  assign diff   = i_data_1 - i_data_2;

  always_comb begin
    res    = '0;
    ovf    = 1'b0;
    ill    = 1'b0;
    is_mul = 1'b0;
    case (i_code)
      FN_ADD: begin
        res = sum;
        ovf = add_ovf(i_data_1[MSB], i_data_2[MSB], sum[MSB]);
      end
      FN_ADDU: res = sum;
      FN_SUB: begin
        res = diff;
        ovf = add_ovf(i_data_1[MSB], ~i_data_2[MSB], diff[MSB]);
      end
      FN_SUBU: res = diff;
      FN_AND:  res = i_data_1 & i_data_2;
      FN_OR:   res = i_data_1 | i_data_2;
      FN_XOR:  res = i_data_1 ^ i_data_2;
      FN_NOR:  res = ~(i_data_1 | i_data_2);
      FN_SLT:  res = {{(NB_DATA-1){1'b0}}, ($signed(i_data_1) < $signed(i_data_2))};
      FN_SLTU: res = {{(NB_DATA-1){1'b0}}, (i_data_1 < i_data_2)};
      FN_SLL:  res = i_data_2 << sh_fix;
      FN_SRL:  res = i_data_2 >> sh_fix;
      FN_SRA:  res = $unsigned($signed(i_data_2) >>> sh_fix);
      FN_SLLV: res = i_data_2 << sh_var;
      FN_SRLV: res = i_data_2 >> sh_var;
      FN_SRAV: res = $unsigned($signed(i_data_2) >>> sh_var);
`ifdef IE_PIPE_MULT_EN
      FN_MFHI: res = hi;
      FN_MFLO: res = lo;
      FN_MULT, FN_MULTU: is_mul = 1'b1;
`endif
      default: ill = 1'b1;
    endcase
  end

  // Multiplies produce no strobe; their result lands in HI/LO instead.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_alu_result <= '0;
      o_rd         <= '0;
      o_overflow   <= 1'b0;
      o_illegal    <= 1'b0;
    end else begin
      o_valid <= accept && !is_mul;
      if (accept && !is_mul) begin
        o_alu_result <= res;
        o_rd         <= i_rd;
        o_overflow   <= ovf;
        o_illegal    <= ill;
      end
    end
  end

`ifdef IE_PIPE_MULT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept && is_mul) state <= ST_MUL;
        ST_MUL:  if (mul_done) state <= ST_DONE;
        ST_DONE: begin
          hi    <= mul_product[2*NB_DATA-1:NB_DATA];
          lo    <= mul_product[NB_DATA-1:0];
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_ready = (state == ST_IDLE);

  ie_mul_iter #(
    .NB_DATA (NB_DATA)
  ) u_mul (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .start     (accept && is_mul),
    .signed_op (i_code == FN_MULT),
    .op_a      (i_data_1),
    .op_b      (i_data_2),
    .done      (mul_done),
    .product   (mul_product)
  );
`else
  assign o_ready = 1'b1;
`endif

endmodule

// File: tb/tb_ie_pipe.sv
// Self-checking bench for ie_pipe: arithmetic reference model with per-cycle compare plus
// hand-computed directed expectations; covers both IE_PIPE_MULT_EN build variants.
module tb_ie_pipe;

  localparam int N = 32;
`ifdef IE_PIPE_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif

  localparam logic [5:0] C_ADD = 6'b100000, C_ADDU = 6'b100001, C_SUB = 6'b100010, C_SUBU = 6'b100011;
  localparam logic [5:0] C_AND = 6'b100100, C_OR = 6'b100101, C_XOR = 6'b100110, C_NOR = 6'b100111;
  localparam logic [5:0] C_SLT = 6'b101010, C_SLTU = 6'b101011, C_SLL = 6'b000000, C_SRL = 6'b000010;
  localparam logic [5:0] C_SRA = 6'b000011, C_SLLV = 6'b000100, C_SRLV = 6'b000110, C_SRAV = 6'b000111;
  localparam logic [5:0] C_MFHI = 6'b010000, C_MFLO = 6'b010010, C_MULT = 6'b011000, C_MULTU = 6'b011001;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_data_1 = '0;
  logic [31:0] i_data_2 = '0;
  logic [4:0]  i_shamt = '0;
  logic [5:0]  i_code = '0;
  logic [4:0]  i_rd = '0;
  logic        o_valid;
  logic [31:0] o_alu_result;
  logic [4:0]  o_rd;
  logic        o_overflow;
  logic        o_illegal;

  ie_pipe #(.NB_DATA(32), .NB_OP(6), .NB_REG(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_1(i_data_1), .i_data_2(i_data_2), .i_shamt(i_shamt), .i_code(i_code), .i_rd(i_rd),
    .o_valid(o_valid), .o_alu_result(o_alu_result), .o_rd(o_rd),
    .o_overflow(o_overflow), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail = 0;
  bit started = 1'b0;

  // Reference model state
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_prod = '0;
  int          m_busy = 0;
  int          cyc = 0;
  bit          m_acc = 1'b0;
  bit          exp_valid = 1'b0, exp_ovf = 1'b0, exp_ill = 1'b0;
  logic [31:0] exp_res = '0;
  logic [4:0]  exp_rd = '0;
  logic [31:0] t_r;
  logic [63:0] t_p;
  bit          t_ov, t_il, t_mul;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic void ref_op(input logic [5:0] code, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [4:0] sh, input logic [31:0] hi, input logic [31:0] lo,
                                 output logic [31:0] r, output bit ov, output bit il, output bit mul,
                                 output logic [63:0] prod);
    longint s;
    r = '0; ov = 1'b0; il = 1'b0; mul = 1'b0; prod = '0; s = 0;
    case (code)
      C_ADD: begin
        s = longint'($signed(rs)) + longint'($signed(rt));
        r = s[31:0];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      C_SUB: begin
        s = longint'($signed(rs)) - longint'($signed(rt));
        r = s[31:0];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      C_ADDU: r = rs + rt;
      C_SUBU: r = rs - rt;
      C_AND:  r = rs & rt;
      C_OR:   r = rs | rt;
      C_XOR:  r = rs ^ rt;
      C_NOR:  r = ~(rs | rt);
      C_SLT:  r = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
      C_SLTU: r = (rs < rt) ? 32'd1 : 32'd0;
      C_SLL:  r = rt << sh;
      C_SRL:  r = rt >> sh;
      C_SRA:  r = $signed(rt) >>> sh;
      C_SLLV: r = rt << (rs % 32);
      C_SRLV: r = rt >> (rs % 32);
      C_SRAV: r = $signed(rt) >>> (rs % 32);
      C_MFHI: if (MULT_EN) r = hi; else il = 1'b1;
      C_MFLO: if (MULT_EN) r = lo; else il = 1'b1;
      C_MULT: if (MULT_EN) begin
        mul = 1'b1;
        prod = longint'($signed(rs)) * longint'($signed(rt));
      end else il = 1'b1;
      C_MULTU: if (MULT_EN) begin
        mul = 1'b1;
        prod = {32'd0, rs} * {32'd0, rt};
      end else il = 1'b1;
      default: il = 1'b1;
    endcase
    if (il) r = '0;
  endfunction

  // Model: busy counter covers the multiply plus its write-back cycle.
  initial forever begin
    @(posedge i_clk or negedge i_rst_n);
    if (!i_rst_n) begin
      m_hi = '0; m_lo = '0; m_busy = 0; m_acc = 1'b0;
      exp_valid = 1'b0; exp_res = '0; exp_rd = '0; exp_ovf = 1'b0; exp_ill = 1'b0;
    end else begin
      cyc++;
      m_acc = 1'b0;
      exp_valid = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_hi = m_prod[63:32];
          m_lo = m_prod[31:0];
        end
      end else if (i_valid) begin
        m_acc = 1'b1;
        ref_op(i_code, i_data_1, i_data_2, i_shamt, m_hi, m_lo, t_r, t_ov, t_il, t_mul, t_p);
        if (t_mul) begin
          m_busy = N + 1;
          m_prod = t_p;
        end else begin
          exp_valid = 1'b1; exp_res = t_r; exp_rd = i_rd; exp_ovf = t_ov; exp_ill = t_il;
        end
      end
    end
  end

  initial forever begin
    @(negedge i_clk);
    if (started) begin
      chkb("cmp_ready", o_ready, (m_busy == 0));
      chkb("cmp_valid", o_valid, exp_valid);
      if (exp_valid) begin
        chk("cmp_result", o_alu_result, exp_res);
        chk("cmp_rd", 32'(o_rd), 32'(exp_rd));
        chkb("cmp_overflow", o_overflow, exp_ovf);
        chkb("cmp_illegal", o_illegal, exp_ill);
      end
    end
  end

  task automatic issue(input logic [5:0] code, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] sh, input logic [4:0] rd);
    bit got;
    got = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b1; i_code = code; i_data_1 = rs; i_data_2 = rt; i_shamt = sh; i_rd = rd;
    for (int k = 0; k < 100 && !got; k++) begin
      @(posedge i_clk);
      #1;
      got = m_acc;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: code %b not accepted within 100 cycles", code);
    end
  endtask

  task automatic idle();
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  localparam int NT = 12;
  logic [5:0]  tc [NT] = '{C_SUB, C_SUBU, C_AND, C_OR, C_XOR, C_NOR, C_SLT, C_SLTU, C_SLL, C_SRL, C_SLLV, C_SRAV};
  logic [31:0] ta [NT] = '{32'h8000_0000, 32'h0000_0001, 32'hF0F0_1234, 32'h0F0F_0000, 32'hFFFF_0000, 32'h1234_5678,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'd33, 32'd68};
  logic [31:0] tb [NT] = '{32'h0000_0001, 32'h0000_0002, 32'hFF00_FF00, 32'h0000_00F0, 32'h0F0F_0F0F, 32'h0000_0000,
                           32'h0000_0001, 32'h0000_0001, 32'h0000_0003, 32'h8000_0000, 32'h4000_0001, 32'h8000_0000};
  logic [4:0]  ts [NT] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd0, 5'd0};

  initial begin
    repeat (2) @(posedge i_clk);
    started = 1'b1;
    @(negedge i_clk);
    chkb("rst_valid", o_valid, 1'b0);
    chk("rst_result", o_alu_result, 32'h0);
    chk("rst_rd", 32'(o_rd), 32'h0);
    chkb("rst_overflow", o_overflow, 1'b0);
    chkb("rst_illegal", o_illegal, 1'b0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chkb("ready_after_rst", o_ready, 1'b1);

    // Back-to-back adds, one result per cycle
    for (int k = 0; k < 5; k++) begin
      issue(C_ADD, 32'((k + 1) / 2 + 1), 32'(k / 2 + 1), 5'd0, 5'(k + 1));
      chkb("b2b_valid", o_valid, 1'b1);
      chk("b2b_result", o_alu_result, 32'(k + 2));
    end

    issue(C_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 5'd7);
    chk("add_ovf_result", o_alu_result, 32'h8000_0000);
    chkb("add_ovf_flag", o_overflow, 1'b1);
    issue(C_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0, 5'd8);
    chk("addu_result", o_alu_result, 32'h8000_0000);
    chkb("addu_no_ovf", o_overflow, 1'b0);
    issue(C_SRA, 32'h0, 32'h8000_0000, 5'd4, 5'd9);
    chk("sra_result", o_alu_result, 32'hF800_0000);
    issue(C_SRLV, 32'd36, 32'h0000_00F0, 5'd0, 5'd10);
    chk("srlv_result", o_alu_result, 32'h0000_000F);
    issue(6'b111111, 32'h5, 32'h7, 5'd3, 5'd11);
    chkb("illegal_flag", o_illegal, 1'b1);
    chk("illegal_result", o_alu_result, 32'h0);
    chk("illegal_rd", 32'(o_rd), 32'd11);

    for (int k = 0; k < NT; k++) issue(tc[k], ta[k], tb[k], ts[k], 5'(k + 12));
    idle();
    repeat (2) @(posedge i_clk);

`ifdef IE_PIPE_MULT_EN
    begin
      int c0, c1;
      issue(C_MULT, 32'hFFFF_FFFD, 32'd5, 5'd0, 5'd1);
      c0 = cyc;
      issue(C_MFHI, 32'h0, 32'h0, 5'd0, 5'd2);
      c1 = cyc;
      chk("mul_stall_cycles", 32'(c1 - c0), 32'(N + 2));
      chk("mfhi_neg", o_alu_result, 32'hFFFF_FFFF);
      issue(C_MFLO, 32'h0, 32'h0, 5'd0, 5'd3);
      chk("mflo_neg", o_alu_result, 32'hFFFF_FFF1);
      issue(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd4);
      issue(C_MFHI, 32'h0, 32'h0, 5'd0, 5'd5);
      chk("mfhi_big", o_alu_result, 32'hFFFF_FFFE);
      issue(C_MFLO, 32'h0, 32'h0, 5'd0, 5'd6);
      chk("mflo_big", o_alu_result, 32'h0000_0001);

      // Reset in the middle of a multiply aborts it
      issue(C_MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0, 5'd7);
      idle();
      repeat (9) @(posedge i_clk);
      @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1 chkb("abort_ready_idle", o_ready, 1'b1);
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      issue(C_MFHI, 32'h0, 32'h0, 5'd0, 5'd8);
      chk("abort_mfhi", o_alu_result, 32'h0);
      issue(C_MFLO, 32'h0, 32'h0, 5'd0, 5'd9);
      chk("abort_mflo", o_alu_result, 32'h0);
    end
`else
    issue(C_MULT, 32'hFFFF_FFFD, 32'd5, 5'd0, 5'd1);
    chkb("mult_dis_illegal", o_illegal, 1'b1);
    chk("mult_dis_result", o_alu_result, 32'h0);
    chkb("mult_dis_ready", o_ready, 1'b1);
    issue(C_MFHI, 32'h0, 32'h0, 5'd0, 5'd2);
    chkb("mfhi_dis_illegal", o_illegal, 1'b1);
    issue(C_MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0, 5'd3);
    chkb("multu_dis_ready", o_ready, 1'b1);
`endif

    idle();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ie_pipe.md
IE_PIPE -- requirements
Module: ie_pipe

Interface
REQ-001 Parameter NB_DATA, 32, datapath width; power of two, at least 8.
REQ-002 Parameter NB_OP, 6, function-code width.
REQ-003 Parameter NB_REG, 5, destination-register index width.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset (polarity and synchronicity fixed); ports are as follows.
REQ-005 i_clk  in  1  clock; all state changes on the rising edge.
REQ-006 i_rst_n  in  1  asynchronous reset, active low.
REQ-007 i_valid  in  1  operation present on the inputs.
REQ-008 o_ready  out  1  block can accept an operation this cycle.
REQ-009 i_data_1  in  NB_DATA  operand rs.
REQ-010 i_data_2  in  NB_DATA  operand rt.
REQ-011 i_shamt  in  5  fixed shift amount.
REQ-012 i_code  in  NB_OP  R-type function code.
REQ-013 i_rd  in  NB_REG  destination register.
REQ-014 o_valid  out  1  one-cycle result strobe.
REQ-015 o_alu_result  out  NB_DATA  registered result.
REQ-016 o_rd  out  NB_REG  destination register paired with o_alu_result.
REQ-017 o_overflow  out  1  signed overflow on ADD/SUB; valid with o_valid.
REQ-018 o_illegal  out  1  unsupported function code; valid with o_valid.

Function
REQ-019 An operation SHALL be accepted when i_valid and o_ready are both 1 on a rising edge.
REQ-020 Single-cycle functions SHALL be supported: ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011, SLL 000000, SRL 000010, SRA 000011, SLLV 000100, SRLV 000110, SRAV 000111, MFHI 010000, MFLO 010010.
REQ-021 Single-cycle results SHALL appear with o_valid=1 on the edge after acceptance (latency 1), with o_valid high for exactly one cycle and no downstream backpressure.
REQ-022 Shift functions SHALL shift rt; the amount is i_shamt for fixed shifts and i_data_1 for variable shifts, in both cases taken modulo NB_DATA.
REQ-023 ADD and SUB SHALL return the wrapped result and set o_overflow=1 on signed overflow; all other functions SHALL drive o_overflow=0.
REQ-024 SLT and SLTU SHALL return 1 or 0, zero-extended to NB_DATA.
REQ-025 An unsupported code SHALL produce o_valid=1, o_illegal=1 and o_alu_result=0.
REQ-026 MULT 011000 (signed) and MULTU 011001 (unsigned) SHALL run an iterative shift-add multiply of NB_DATA cycles and write the 2*NB_DATA product to internal HI (upper half) and LO (lower half).
REQ-027 The multiply FSM SHALL have three states: IDLE, then MUL on a MULT/MULTU accept, then DONE after NB_DATA iterations, then IDLE on the next cycle.
REQ-028 o_ready SHALL be 1 only in IDLE, so an MFHI or MFLO presented during a multiply stalls until the multiply completes.
REQ-029 MULT/MULTU SHALL NOT assert o_valid; HI and LO SHALL update in DONE.
REQ-030 An MFHI or MFLO accepted in the cycle after DONE SHALL return the new value.
REQ-031 MULT SHALL multiply operand magnitudes and negate the product when the operand signs differ.
REQ-032 Inputs presented while o_ready=0 SHALL be ignored and SHALL NOT be captured.

Reset
REQ-033 While i_rst_n=0: o_valid=0, o_alu_result=0, o_rd=0, o_overflow=0, o_illegal=0, HI=0, LO=0, FSM=IDLE.
REQ-034 o_ready SHALL be 1 one cycle after reset release.
REQ-035 Reset asserted during MUL SHALL abort the multiply and leave HI and LO at 0.

Configuration
REQ-036 Macro IE_PIPE_MULT_EN defined: MULT, MULTU, MFHI, MFLO, HI, LO and the FSM SHALL be present.
REQ-037 Macro IE_PIPE_MULT_EN undefined: those four codes SHALL be treated as illegal (REQ-025), and o_ready SHALL be tied to 1.

Structure
REQ-038 The function-code localparams, the FSM state encoding and the NB_* defaults SHALL live in shared package ie_pkg.
REQ-039 The iterative multiplier SHALL be one sub-module, ie_mul_iter, with start/done handshake.

Verification
REQ-040 ADD 1+1, then 1+2, 2+2, 2+3, 3+3 back-to-back -> o_alu_result 2, 3, 4, 5, 6, each one cycle after accept, with o_valid pulsed each cycle.
REQ-041 ADD 0x7FFFFFFF+1 -> result 0x80000000 with o_overflow=1; ADDU with the same operands -> o_overflow=0.
REQ-042 SRA rt=0x80000000, shamt=4 -> 0xF8000000; SRLV rs=36, rt=0xF0 -> 0x0F.
REQ-043 MULT -3*5, then MFHI and MFLO -> o_ready low for NB_DATA+1 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-044 MULTU 0xFFFFFFFF*2, then i_rst_n=0 at iteration 10 -> FSM IDLE and MFHI returns 0.
REQ-045 i_code=111111 -> o_illegal=1 and o_alu_result=0; with IE_PIPE_MULT_EN undefined, MULT -> o_illegal=1 and o_ready stays 1.
